exu_csr_file: RTL and testbench

EXU_CSR_FILE -- requirements
Module: exu_csr_file

---
 rtl/exu_csr_file_pkg.sv | 92 +++++++++
 rtl/exu_csr_file_cnt64.sv | 29 ++
 rtl/exu_csr_file.sv | 147 ++++++++++++++
 tb/tb_exu_csr_file.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_csr_file_pkg.sv
// rtl/exu_csr_file_pkg.sv - CSR addresses, bit indices, cause codes and decode for exu_csr_file (CSR_CYCLE_CNT_EN)
package exu_csr_file_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    localparam logic [31:0] MCAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

    localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_MSTATUS,
        SEL_MISA,
        SEL_MIE,
        SEL_MTVEC,
        SEL_MSCRATCH,
        SEL_MEPC,
        SEL_MCAUSE,
        SEL_MTVAL,
        SEL_MIP,
        SEL_MHARTID,
        SEL_MCYCLE,
        SEL_MCYCLEH,
        SEL_MINSTRET,
        SEL_MINSTRETH
    } csr_sel_e;

    function automatic csr_sel_e csr_decode(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS:   return SEL_MSTATUS;
            CSR_MISA:      return SEL_MISA;
            CSR_MIE:       return SEL_MIE;
            CSR_MTVEC:     return SEL_MTVEC;
            CSR_MSCRATCH:  return SEL_MSCRATCH;
            CSR_MEPC:      return SEL_MEPC;
            CSR_MCAUSE:    return SEL_MCAUSE;
            CSR_MTVAL:     return SEL_MTVAL;
            CSR_MIP:       return SEL_MIP;
            CSR_MHARTID:   return SEL_MHARTID;
`ifdef CSR_CYCLE_CNT_EN
            CSR_MCYCLE:    return SEL_MCYCLE;
            CSR_MCYCLEH:   return SEL_MCYCLEH;
            CSR_MINSTRET:  return SEL_MINSTRET;
            CSR_MINSTRETH: return SEL_MINSTRETH;
`endif
            default:       return SEL_NONE;
        endcase
    endfunction

    // Interrupt triples are ordered {external, timer, software} everywhere.
    function automatic logic [31:0] irq_word(input logic [2:0] bits);
        logic [31:0] w;
        w           = '0;
        w[MIP_MEIP] = bits[2];
        w[MIP_MTIP] = bits[1];
        w[MIP_MSIP] = bits[0];
        return w;
    endfunction

    function automatic logic [31:0] mstatus_word(input logic mie, input logic mpie);
        logic [31:0] w;
        w               = '0;
        w[12:11]        = MSTATUS_MPP_M;
        w[MSTATUS_MPIE] = mpie;
        w[MSTATUS_MIE]  = mie;
        return w;
    endfunction

endpackage

// File: rtl/exu_csr_file_cnt64.sv
// rtl/exu_csr_file_cnt64.sv - csr_cnt64: 64-bit wrapping counter with split 32-bit write
module csr_cnt64 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] count;

    // A write to either half takes precedence and suppresses that cycle's increment.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_wr_lo) begin
            count[31:0] <= i_wdata;
        end else if (i_wr_hi) begin
            count[63:32] <= i_wdata;
        end else if (i_inc) begin
            count <= count + 64'd1;
        end
    end

    assign o_count = count;

endmodule

// File: rtl/exu_csr_file.sv
// rtl/exu_csr_file.sv - Machine-mode CSR file; CSR_CYCLE_CNT_EN adds mcycle/minstret counters
module exu_csr_file
    import exu_csr_file_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MHARTID   = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_csr_addr,
    input  logic        i_csr_wen,
    input  logic [31:0] i_csr_wdata,
    output logic [31:0] o_csr_rdata,
    output logic        o_csr_illegal,
    input  logic        i_irq_ext,
    input  logic        i_irq_tmr,
    input  logic        i_irq_sft,
    input  logic        i_trap_valid,
    input  logic [31:0] i_trap_cause,
    input  logic [31:0] i_trap_pc,
    input  logic [31:0] i_trap_tval,
    input  logic        i_mret,
    input  logic        i_instret,
    output logic [31:0] o_mtvec,
    output logic [31:0] o_mepc,
    output logic        o_irq_req
);

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [2:0]  mie_q;
    logic [2:0]  mip_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;

    csr_sel_e sel;
    logic     read_only;
    logic     wr_ok;

    assign sel           = csr_decode(i_csr_addr);
    assign read_only     = (sel == SEL_MHARTID) || (sel == SEL_MISA) || (sel == SEL_MIP);
    assign o_csr_illegal = (sel == SEL_NONE) || (i_csr_wen && read_only);
    assign wr_ok         = i_csr_wen && !o_csr_illegal;

    // Trap owns mstatus/mepc/mcause/mtval that cycle; mret owns mstatus.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mip_q        <= '0;
            mtvec_q      <= MTVEC_RST;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
        end else begin
            mip_q <= {i_irq_ext, i_irq_tmr, i_irq_sft};
            if (i_trap_valid) begin
                mepc_q       <= i_trap_pc;
                mcause_q     <= i_trap_cause;
                mtval_q      <= i_trap_tval;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (i_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
            if (wr_ok) begin
                case (sel)
                    SEL_MSTATUS: begin
                        if (!i_trap_valid && !i_mret) begin
                            mstatus_mie  <= i_csr_wdata[MSTATUS_MIE];
                            mstatus_mpie <= i_csr_wdata[MSTATUS_MPIE];
                        end
                    end
                    SEL_MIE:      mie_q      <= {i_csr_wdata[MIP_MEIP], i_csr_wdata[MIP_MTIP], i_csr_wdata[MIP_MSIP]};
                    SEL_MTVEC:    mtvec_q    <= {i_csr_wdata[31:2], 2'b00};
                    SEL_MSCRATCH: mscratch_q <= i_csr_wdata;
                    SEL_MEPC:     if (!i_trap_valid) mepc_q   <= {i_csr_wdata[31:2], 2'b00};
                    SEL_MCAUSE:   if (!i_trap_valid) mcause_q <= i_csr_wdata;
                    SEL_MTVAL:    if (!i_trap_valid) mtval_q  <= i_csr_wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_CYCLE_CNT_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;

    csr_cnt64 u_mcycle (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (1'b1),
        .i_wr_lo (wr_ok && (sel == SEL_MCYCLE)),
        .i_wr_hi (wr_ok && (sel == SEL_MCYCLEH)),
        .i_wdata (i_csr_wdata),
        .o_count (mcycle)
    );

    csr_cnt64 u_minstret (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (i_instret),
        .i_wr_lo (wr_ok && (sel == SEL_MINSTRET)),
        .i_wr_hi (wr_ok && (sel == SEL_MINSTRETH)),
        .i_wdata (i_csr_wdata),
        .o_count (minstret)
    );
`else
    logic unused_instret;
    assign unused_instret = i_instret;
`endif

    always_comb begin
        o_csr_rdata = '0;
        case (sel)
            SEL_MSTATUS:   o_csr_rdata = mstatus_word(mstatus_mie, mstatus_mpie);
            SEL_MISA:      o_csr_rdata = MISA_RV32I;
            SEL_MIE:       o_csr_rdata = irq_word(mie_q);
            SEL_MTVEC:     o_csr_rdata = mtvec_q;
            SEL_MSCRATCH:  o_csr_rdata = mscratch_q;
            SEL_MEPC:      o_csr_rdata = mepc_q;
            SEL_MCAUSE:    o_csr_rdata = mcause_q;
            SEL_MTVAL:     o_csr_rdata = mtval_q;
            SEL_MIP:       o_csr_rdata = irq_word(mip_q);
            SEL_MHARTID:   o_csr_rdata = MHARTID;
`ifdef CSR_CYCLE_CNT_EN
            SEL_MCYCLE:    o_csr_rdata = mcycle[31:0];
            SEL_MCYCLEH:   o_csr_rdata = mcycle[63:32];
            SEL_MINSTRET:  o_csr_rdata = minstret[31:0];
            SEL_MINSTRETH: o_csr_rdata = minstret[63:32];
`endif
            default:       o_csr_rdata = '0;
        endcase
    end

    assign o_irq_req = mstatus_mie && |(mie_q & mip_q);
    assign o_mtvec   = mtvec_q;
    assign o_mepc    = mepc_q;

endmodule

// File: tb/tb_exu_csr_file.sv
// tb/tb_exu_csr_file.sv - Randomized bench for exu_csr_file against a behavioural CSR model (CSR_CYCLE_CNT_EN aware)
module tb_exu_csr_file;

    localparam logic [31:0] P_MTVEC_RST = 32'h0000_1000;
    localparam logic [31:0] P_HART      = 32'd3;
`ifdef CSR_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        irq_ext, irq_tmr, irq_sft;
    logic        trap_valid;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        mret;
    logic        instret;
    logic [31:0] mtvec_o, mepc_o;
    logic        irq_req;

    always #5 clk = ~clk;

    exu_csr_file #(.MTVEC_RST(P_MTVEC_RST), .MHARTID(P_HART)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_csr_addr   (csr_addr),
        .i_csr_wen    (csr_wen),
        .i_csr_wdata  (csr_wdata),
        .o_csr_rdata  (csr_rdata),
        .o_csr_illegal(csr_illegal),
        .i_irq_ext    (irq_ext),
        .i_irq_tmr    (irq_tmr),
        .i_irq_sft    (irq_sft),
        .i_trap_valid (trap_valid),
        .i_trap_cause (trap_cause),
        .i_trap_pc    (trap_pc),
        .i_trap_tval  (trap_tval),
        .i_mret       (mret),
        .i_instret    (instret),
        .o_mtvec      (mtvec_o),
        .o_mepc       (mepc_o),
        .o_irq_req    (irq_req)
    );

    int checks = 0;
    int errors = 0;

    bit          m_valid = 1'b0;
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_mcycle, m_minstret;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_read(input logic [11:0] a, input bit wen,
                                       output logic [31:0] d, output bit ill);
        bit impl = 1'b1;
        bit ro   = 1'b0;
        d = '0;
        case (a)
            12'h300: d = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: begin d = 32'h4000_0100; ro = 1'b1; end
            12'h304: d = m_mie_reg;
            12'h305: d = m_mtvec;
            12'h340: d = m_mscratch;
            12'h341: d = m_mepc;
            12'h342: d = m_mcause;
            12'h343: d = m_mtval;
            12'h344: begin d = m_mip; ro = 1'b1; end
            12'hF14: begin d = P_HART; ro = 1'b1; end
            12'hB00: if (CNT_EN) d = m_mcycle[31:0];    else impl = 1'b0;
            12'hB80: if (CNT_EN) d = m_mcycle[63:32];   else impl = 1'b0;
            12'hB02: if (CNT_EN) d = m_minstret[31:0];  else impl = 1'b0;
            12'hB82: if (CNT_EN) d = m_minstret[63:32]; else impl = 1'b0;
            default: impl = 1'b0;
        endcase
        ill = !impl || (wen && ro);
    endfunction

    task automatic model_update();
        logic [31:0] dummy;
        bit          ill, wr;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mip = 0; m_mtvec = P_MTVEC_RST;
            m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_mcycle = 0; m_minstret = 0;
            m_valid = 1'b1;
            return;
        end
        model_read(csr_addr, csr_wen, dummy, ill);
        wr = csr_wen && !ill;
        if (CNT_EN) begin
            if (wr && csr_addr == 12'hB00)      m_mcycle[31:0]  = csr_wdata;
            else if (wr && csr_addr == 12'hB80) m_mcycle[63:32] = csr_wdata;
            else                                m_mcycle = m_mcycle + 1;
            if (wr && csr_addr == 12'hB02)      m_minstret[31:0]  = csr_wdata;
            else if (wr && csr_addr == 12'hB82) m_minstret[63:32] = csr_wdata;
            else if (instret)                   m_minstret = m_minstret + 1;
        end
        if (trap_valid) begin
            m_mepc = trap_pc; m_mcause = trap_cause; m_mtval = trap_tval;
            m_mpie = m_mie; m_mie = 0;
        end else if (mret) begin
            m_mie = m_mpie; m_mpie = 1;
        end
        if (wr) begin
            case (csr_addr)
                12'h300: if (!trap_valid && !mret) begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                12'h304: m_mie_reg = csr_wdata & 32'h888;
                12'h305: m_mtvec = csr_wdata & ~32'h3;
                12'h340: m_mscratch = csr_wdata;
                12'h341: if (!trap_valid) m_mepc = csr_wdata & ~32'h3;
                12'h342: if (!trap_valid) m_mcause = csr_wdata;
                12'h343: if (!trap_valid) m_mtval = csr_wdata;
                default: ;
            endcase
        end
        m_mip = (irq_ext ? 32'h800 : 32'h0) | (irq_tmr ? 32'h80 : 32'h0) | (irq_sft ? 32'h8 : 32'h0);
    endtask

    always @(negedge clk) begin : compare_proc
        logic [31:0] d;
        bit          ill;
        if (m_valid) begin
            model_read(csr_addr, csr_wen, d, ill);
            cmp("rdata", csr_rdata, d);
            cmp("illegal", 32'(csr_illegal), 32'(ill));
            cmp("mtvec", mtvec_o, m_mtvec);
            cmp("mepc", mepc_o, m_mepc);
            cmp("irq_req", 32'(irq_req), 32'(m_mie && ((m_mie_reg & m_mip) != 0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
        csr_addr = a; csr_wdata = d; csr_wen = 1'b1;
        tick();
        csr_wen = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        cmp(name, csr_rdata, exp);
    endtask

    logic [11:0] addrs [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h000};

    initial begin
        rst = 1; csr_addr = 0; csr_wen = 0; csr_wdata = 0;
        irq_ext = 0; irq_tmr = 0; irq_sft = 0;
        trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0; mret = 0; instret = 0;
        tick(); tick();
        rst = 0;
        settle();
        cmp("rst_mtvec", mtvec_o, 32'h0000_1000);
        cmp("rst_mepc", mepc_o, 32'h0);
        cmp("rst_irq_req", 32'(irq_req), 32'h0);
        rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);

        wr_csr(12'h305, 32'h8000_0101);
        settle();
        cmp("mtvec_align_out", mtvec_o, 32'h8000_0100);
        rd_chk("mtvec_align_rd", 12'h305, 32'h8000_0100);

        csr_addr = 12'hF14; csr_wdata = 32'hDEAD_BEEF; csr_wen = 1'b1;
        #1;
        cmp("hartid_wr_illegal", 32'(csr_illegal), 32'h1);
        tick();
        csr_wen = 1'b0;
        settle();
        rd_chk("hartid_unchanged", 12'hF14, 32'd3);
        rd_chk("unimpl_rd", 12'h7C0, 32'h0);
        cmp("unimpl_illegal", 32'(csr_illegal), 32'h1);
        rd_chk("misa_rd", 12'h301, 32'h4000_0100);

        wr_csr(12'h300, 32'h0000_0008);
        wr_csr(12'h304, 32'h0000_0080);
        irq_tmr = 1'b1;
        settle();
        cmp("irq_before_sample", 32'(irq_req), 32'h0);
        tick();
        settle();
        cmp("irq_after_sample", 32'(irq_req), 32'h1);
        irq_tmr = 1'b0;

        trap_valid = 1; trap_pc = 32'h100; trap_cause = 32'h8000_0007; trap_tval = 32'h55;
        tick();
        trap_valid = 0;
        settle();
        cmp("trap_mepc", mepc_o, 32'h100);
        rd_chk("trap_mcause", 12'h342, 32'h8000_0007);
        rd_chk("trap_mstatus", 12'h300, 32'h0000_1880);
        mret = 1;
        tick();
        mret = 0;
        settle();
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);

        trap_valid = 1; mret = 1; trap_pc = 32'h200; trap_cause = 32'hB;
        csr_addr = 12'h340; csr_wdata = 32'h1234; csr_wen = 1;
        tick();
        trap_valid = 0; mret = 0; csr_wen = 0;
        settle();
        rd_chk("trap_mret_mstatus", 12'h300, 32'h0000_1880);
        rd_chk("trap_side_write", 12'h340, 32'h1234);
        cmp("trap_mret_mepc", mepc_o, 32'h200);
        trap_valid = 1; trap_pc = 32'h300;
        csr_addr = 12'h341; csr_wdata = 32'h999; csr_wen = 1;
        tick();
        trap_valid = 0; csr_wen = 0;
        settle();
        cmp("trap_beats_mepc_write", mepc_o, 32'h300);

`ifdef CSR_CYCLE_CNT_EN
        wr_csr(12'hB00, 32'hFFFF_FFFF);
        wr_csr(12'hB80, 32'hFFFF_FFFF);
        tick();
        settle();
        rd_chk("mcycle_wrap_lo", 12'hB00, 32'h0);
        rd_chk("mcycle_wrap_hi", 12'hB80, 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(63) == 0);
            csr_addr   = addrs[$urandom_range(15)];
            csr_wen    = 1'($urandom_range(1));
            csr_wdata  = $urandom;
            irq_ext    = 1'($urandom_range(1));
            irq_tmr    = 1'($urandom_range(1));
            irq_sft    = 1'($urandom_range(1));
            trap_valid = ($urandom_range(9) == 0);
            mret       = ($urandom_range(7) == 0);
            trap_cause = $urandom;
            trap_pc    = $urandom;
            trap_tval  = $urandom;
            instret    = 1'($urandom_range(1));
            tick();
        end
        rst = 0; csr_wen = 0; trap_valid = 0; mret = 0;
        tick();
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
